bandscope_streamer: RTL

Drains one completed 4096-sample bandscope capture from the bandscope RAM and streams it to the host interface as a byte stream with packet framing. Sits directly downstream of the bandscope capture controller: it starts on each toggle of that controller's `bs_ready`, reads the RAM through its second (read) port, and feeds the host packet sender over a valid/ready byte handshake. The block is the only reader of the bandscope RAM.

---
 rtl/bandscope_streamer_if.sv | 7 +
 rtl/bandscope_streamer.sv | 106 ++++++++++
 2 files changed

// File: rtl/bandscope_streamer_if.sv
// bandscope_streamer_if: valid/ready byte stream toward the host packet sender.
interface bandscope_streamer_if;
  logic [7:0] out_data;
  logic out_valid, out_ready, out_last;
  modport master(output out_data, out_valid, out_last, input out_ready);
  modport slave(input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/bandscope_streamer.sv
// bandscope_streamer: drains a 4096-sample bandscope frame from RAM as 16 framed byte packets.
module bandscope_streamer #(
  parameter int RD_LAT = 2,
  parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic bs_on,
  input  logic bs_ready,
  output logic [11:0] rd_addr,
  input  logic [15:0] mem_q,
  bandscope_streamer_if.master out,
  output logic busy,
  output logic [7:0] overrun
);
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  state_t state_q, state_d;
  logic bs_old_q, lsb_q, lsb_d;
  logic [3:0] pkt_q, pkt_d, seq_q, seq_d;
  logic [7:0] cnt_q, cnt_d, ovr_q, ovr_d;
  logic [12:0] iss_q, iss_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [15:0] fifo_q [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] occ_q, occ_d, infl;
  logic start, xfer, pop, ret, issue;
  logic [15:0] head;
  assign rd_addr = iss_q[11:0];
  assign overrun = ovr_q;
  if (RD_LAT == 1) begin : g_l1
    assign vld_d = issue;
  end else begin : g_ln
    assign vld_d = {vld_q[RD_LAT-2:0], issue};
  end
  always_comb begin
    start = bs_ready != bs_old_q;
    busy = state_q != IDLE;
    ret = vld_q[RD_LAT-1];
    infl = 3'($countones(vld_q));
    // an empty FIFO forwards the returning RAM word so a fresh frame has no bubble
    head = occ_q == 3'd0 ? mem_q : fifo_q[rp_q];
    out.out_valid = state_q == HDR0 || state_q == HDR1 || (state_q == DATA && (occ_q != 3'd0 || ret));
    out.out_data = state_q == HDR0 ? HDR_MAGIC : state_q == HDR1 ? {seq_q, pkt_q} :
                   state_q == DATA ? (lsb_q ? head[7:0] : head[15:8]) : 8'h00;
    out.out_last = state_q == DATA && lsb_q && cnt_q == 8'hff;
    xfer = out.out_valid && out.out_ready;
    pop = xfer && state_q == DATA && lsb_q;
    issue = busy && !iss_q[12] && occ_q + infl < 3'd4;
    state_d = state_q;
    pkt_d = pkt_q;
    seq_d = seq_q;
    cnt_d = cnt_q;
    lsb_d = lsb_q;
    ovr_d = ovr_q + 8'(start && busy && bs_on && ovr_q != 8'hff);
    iss_d = iss_q + 13'(issue);
    wp_d = wp_q + 2'(ret);
    rp_d = rp_q + 2'(pop);
    occ_d = occ_q + 3'(ret) - 3'(pop);
    if (!busy && start && bs_on) begin
      state_d = HDR0;
      pkt_d = 4'h0;
      iss_d = 13'h0;
    end else if (xfer) begin
      if (state_q == HDR0) state_d = HDR1;
      else if (state_q == HDR1) state_d = DATA;
      else begin
        lsb_d = !lsb_q;
        cnt_d = cnt_q + 8'(lsb_q);
        if (out.out_last) begin
          state_d = pkt_q == 4'hf ? IDLE : HDR0;
          pkt_d = pkt_q + 4'h1;
          seq_d = seq_q + 4'(pkt_q == 4'hf);
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    bs_old_q <= bs_ready;
    if (ret) fifo_q[wp_q] <= mem_q;
    if (reset) begin
      state_q <= IDLE;
      pkt_q <= '0;
      seq_q <= '0;
      cnt_q <= '0;
      lsb_q <= 1'b0;
      ovr_q <= '0;
      iss_q <= '0;
      vld_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      seq_q <= seq_d;
      cnt_q <= cnt_d;
      lsb_q <= lsb_d;
      ovr_q <= ovr_d;
      iss_q <= iss_d;
      vld_q <= vld_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
    end
  end
endmodule
